axi_lite_regif: RTL and testbench
=================================

Name: axi_lite_regif

Overview:
Parametrised AXI4-Lite slave front-end that converts AXI4-Lite bus transactions into single-beat register-file strobes. It generalises the single-channel slave in four ways: configurable data width, WSTRB byte enables, BRESP/RRESP error signalling for out-of-range addresses, and a bounded read wait with timeout. It sits between the AXI interconnect and the PWM register file or any other register bank.

Parameters:
ADDR_WIDTH, 8, AXI byte-address width.
DATA_WIDTH, 32, data width in bits; legal values are 16, 32 or 64.
NUM_REGS, 8, number of implemented word registers; valid indices are 0..NUM_REGS-1.
RD_TIMEOUT, 15, maximum number of cycles to wait for rd_valid after rd_en; must be 1..255.

Ports:
ACLK  in  1  clock; all logic is rising-edge.
ARESET  in  1  synchronous, active-high reset.
AWVALID  in  1  write address valid.
AWREADY  out  1  write address ready.
AWADDR  in  ADDR_WIDTH  write byte address.
WVALID  in  1  write data valid.
WREADY  out  1  write data ready.
WDATA  in  DATA_WIDTH  write data.
WSTRB  in  DATA_WIDTH/8  write byte enables.
BVALID  out  1  write response valid.
BREADY  in  1  write response ready.
BRESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
ARVALID  in  1  read address valid.
ARREADY  out  1  read address ready.
ARADDR  in  ADDR_WIDTH  read byte address.
RVALID  out  1  read data valid.
RREADY  in  1  read data ready.
RDATA  out  DATA_WIDTH  read data (registered).
RRESP  out  2  read response: OKAY or SLVERR.
wr_en  out  1  one-cycle write strobe to the register file.
wr_idx  out  $clog2(NUM_REGS)  word index of the write.
wr_data  out  DATA_WIDTH  write data.
wr_strb  out  DATA_WIDTH/8  byte enables of the write.
rd_en  out  1  one-cycle read request strobe.
rd_idx  out  $clog2(NUM_REGS)  word index of the read.
rd_data  in  DATA_WIDTH  read data from the register file.
rd_valid  in  1  qualifies rd_data; may arrive 0..N cycles after rd_en.

Behaviour:
- Reset values (ARESET sampled high): AWREADY=WREADY=ARREADY=1; BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0; wr_en=rd_en=0; all holding registers cleared. Asserting ARESET mid-transaction aborts it with no strobe and no response.
- Address decode: index = ADDR[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]. The low byte-offset bits are ignored. An index >= NUM_REGS is an error.
- Write capture:
  - AW and W are accepted independently, in either order or in the same cycle.
  - AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID.
  - AWADDR, WDATA and WSTRB are registered on their respective handshakes.
- Write execute:
  - If both handshakes are complete by cycle N, then in cycle N+1 BVALID rises.
  - In the same cycle N+1, if the index is valid, wr_en pulses for exactly one cycle with wr_idx, wr_data and wr_strb stable; BRESP=OKAY.
  - If the index is invalid, there is no wr_en pulse and BRESP=SLVERR.
  - WSTRB=0 is still a valid write: wr_en pulses with wr_strb=0 and the response is OKAY.
- Write response: BVALID and BRESP are held until BREADY. The held flags clear on the B handshake, and AWREADY/WREADY return to 1 in the following cycle. Total throughput is at most one write per 2 cycles.
- Read FSM has three states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: ARREADY=1. On the AR handshake in cycle N, ARADDR is latched and ARREADY drops.
    - Valid index: go to R_WAIT; rd_en pulses in cycle N+1 with rd_idx.
    - Invalid index: go to R_RESP; RVALID in cycle N+1 with RDATA=0 and RRESP=SLVERR; no rd_en.
  - R_WAIT: an 8-bit counter starts at 0 on entry.
    - rd_valid is sampled from cycle N+1 onward, including the rd_en cycle itself (zero-wait register file).
    - On rd_valid: RDATA<=rd_data, RRESP<=OKAY, go to R_RESP.
    - If the counter reaches RD_TIMEOUT without rd_valid: RDATA<=0, RRESP<=SLVERR, go to R_RESP. A late rd_valid is then ignored.
  - R_RESP: RVALID=1; RDATA and RRESP are held stable until RREADY. On the R handshake go to R_IDLE (ARREADY=1 the next cycle).
- The read and write paths are fully independent. wr_en and rd_en may pulse in the same cycle; ordering between them is the register file's concern.
- No combinational path from any input to AWREADY, WREADY, ARREADY, BVALID or RVALID.

Test Plan:
- Write ordering: AW (addr 0x08) then W (0xDEADBEEF, strb 0xF) 3 cycles later -> one wr_en pulse with wr_idx=2, wr_data=0xDEADBEEF; BVALID in the same cycle; BRESP=00. Repeat with W before AW and with AW/W in the same cycle -> identical strobe, one cycle after the second handshake.
- Back-pressure: hold BREADY=0 for 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0, exactly one wr_en pulse; a new AW offered meanwhile is not accepted until the cycle after the B handshake.
- Out-of-range (NUM_REGS=8): write to 0x40 -> no wr_en, BRESP=10. Read from 0x7C -> no rd_en, RVALID at N+1, RDATA=0, RRESP=10.
- Read latency: ARADDR=0x04 with rd_valid 0, 3 and RD_TIMEOUT-1 cycles after rd_en -> RDATA = rd_data, RRESP=00. With rd_valid never asserted -> RVALID after RD_TIMEOUT cycles, RDATA=0, RRESP=10.
- Concurrency and back-pressure: simultaneous AR and AW/W handshakes -> rd_en and wr_en pulse in the same cycle, both responses correct; with RREADY held low 4 cycles, RDATA does not change when rd_data changes.
- Reset: assert ARESET for 1 cycle while in R_WAIT and while BVALID=1 -> all outputs at reset values next cycle, no late strobes; a fresh write then completes normally. Exercise DATA_WIDTH=16 (index from ADDR[7:1], wr_strb 2 bits).

Source files
------------

// File: rtl/axi_lite_regif_if.sv
// axi_lite_regif_if: AXI4-Lite bus bundle between an interconnect master and a register slave
interface axi_lite_regif_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                    AWVALID;
    logic                    AWREADY;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    WVALID;
    logic                    WREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    BVALID;
    logic                    BREADY;
    logic [1:0]              BRESP;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    RVALID;
    logic                    RREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;

    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_lite_regif.sv
// axi_lite_regif: AXI4-Lite slave turning bus transactions into single-beat register-file strobes
module axi_lite_regif #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int RD_TIMEOUT = 15,
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int SW = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    axi_lite_regif_if.slave       bus,
    output logic                  wr_en,
    output logic [IW-1:0]         wr_idx,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [SW-1:0]         wr_strb,
    output logic                  rd_en,
    output logic [IW-1:0]         rd_idx,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_valid
);
    localparam int OFF = $clog2(SW);
    localparam int XW  = ADDR_WIDTH - OFF;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    function automatic logic in_range(input logic [XW-1:0] x);
        return 32'(x) < NUM_REGS;
    endfunction

    function automatic logic [IW-1:0] idx_of(input logic [XW-1:0] x);
        return IW'(x);
    endfunction

    logic                  aw_held;
    logic                  w_held;
    logic                  bvalid;
    logic [1:0]            bresp;
    logic [XW-1:0]         awidx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]         wstrb_q;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  wr_fire;
    logic [XW-1:0]         widx;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]         wstrb;

    logic [1:0]            rstate;
    logic [XW-1:0]         aridx_q;
    logic [7:0]            cnt;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;

    assign bus.AWREADY = !aw_held && !bvalid;
    assign bus.WREADY  = !w_held && !bvalid;
    assign bus.BVALID  = bvalid;
    assign bus.BRESP   = bresp;
    assign bus.ARREADY = rstate == R_IDLE;
    assign bus.RVALID  = rstate == R_RESP;
    assign bus.RDATA   = rdata;
    assign bus.RRESP   = rresp;
    assign rd_idx      = idx_of(aridx_q);

    // Write merge: take each field from its holding register once captured, else straight off the bus
    always_comb begin
        aw_hs   = bus.AWVALID && bus.AWREADY;
        w_hs    = bus.WVALID && bus.WREADY;
        widx    = aw_held ? awidx_q : bus.AWADDR[ADDR_WIDTH-1:OFF];
        wdata   = w_held ? wdata_q : bus.WDATA;
        wstrb   = w_held ? wstrb_q : bus.WSTRB;
        wr_fire = (aw_held || aw_hs) && (w_held || w_hs) && !bvalid;
    end

    // Write path: independent AW/W capture, one strobe plus response once both halves are in
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            awidx_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
            wr_en   <= 1'b0;
            wr_idx  <= '0;
            wr_data <= '0;
            wr_strb <= '0;
        end else begin
            wr_en <= 1'b0;
            if (aw_hs) begin
                aw_held <= 1'b1;
                awidx_q <= bus.AWADDR[ADDR_WIDTH-1:OFF];
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= bus.WDATA;
                wstrb_q <= bus.WSTRB;
            end
            if (wr_fire) begin
                bvalid  <= 1'b1;
                bresp   <= in_range(widx) ? OKAY : SLVERR;
                wr_en   <= in_range(widx);
                wr_idx  <= idx_of(widx);
                wr_data <= wdata;
                wr_strb <= wstrb;
            end
            if (bvalid && bus.BREADY) begin
                bvalid  <= 1'b0;
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Read path: request strobe, bounded wait for the register file, then hold the response
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rstate  <= R_IDLE;
            aridx_q <= '0;
            cnt     <= '0;
            rdata   <= '0;
            rresp   <= OKAY;
            rd_en   <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            case (rstate)
                R_IDLE: if (bus.ARVALID) begin
                    aridx_q <= bus.ARADDR[ADDR_WIDTH-1:OFF];
                    cnt     <= '0;
                    if (in_range(bus.ARADDR[ADDR_WIDTH-1:OFF])) begin
                        rd_en  <= 1'b1;
                        rstate <= R_WAIT;
                    end else begin
                        rdata  <= '0;
                        rresp  <= SLVERR;
                        rstate <= R_RESP;
                    end
                end
                R_WAIT: if (rd_valid) begin
                    rdata  <= rd_data;
                    rresp  <= OKAY;
                    rstate <= R_RESP;
                end else if (cnt + 8'd1 == 8'(RD_TIMEOUT)) begin
                    rdata  <= '0;
                    rresp  <= SLVERR;
                    rstate <= R_RESP;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                R_RESP: if (bus.RREADY) rstate <= R_IDLE;
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_regif.sv
// tb_axi_lite_regif: scoreboard bench for the AXI4-Lite register front-end (32-bit and 16-bit builds)
module tb_axi_lite_regif;
    localparam int RDT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    axi_lite_regif_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();
    axi_lite_regif_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus16 ();

    logic        wr_en, rd_en, rd_valid;
    logic [2:0]  wr_idx, rd_idx;
    logic [31:0] wr_data, rd_data;
    logic [3:0]  wr_strb;

    logic        wr_en16, rd_en16;
    logic [2:0]  wr_idx16, rd_idx16;
    logic [15:0] wr_data16;
    logic [1:0]  wr_strb16;
    logic [15:0] rd_data16 = '0;
    logic        rd_valid16 = 1'b0;

    axi_lite_regif #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(8), .RD_TIMEOUT(RDT)) dut (
        .ACLK(clk), .ARESET(rst), .bus(bus),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    axi_lite_regif #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .NUM_REGS(8), .RD_TIMEOUT(RDT)) dut16 (
        .ACLK(clk), .ARESET(rst), .bus(bus16),
        .wr_en(wr_en16), .wr_idx(wr_idx16), .wr_data(wr_data16), .wr_strb(wr_strb16),
        .rd_en(rd_en16), .rd_idx(rd_idx16), .rd_data(rd_data16), .rd_valid(rd_valid16)
    );

    typedef struct {int c; logic [2:0] i; logic [31:0] d; logic [3:0] s;} wr_t;
    typedef struct {int c; logic [1:0] r;} b_t;
    typedef struct {int c; logic [2:0] i;} rq_t;
    typedef struct {int c; logic [31:0] d; logic [1:0] r;} r_t;
    typedef struct {int c; logic [2:0] i; logic [15:0] d; logic [1:0] s;} w16_t;

    wr_t  q_wr[$];
    b_t   q_b[$];
    rq_t  q_rd[$];
    r_t   q_r[$];
    w16_t q_w16[$];

    int          rd_delay = 0;
    logic [31:0] rd_val = '0;

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Register-file model: answers rd_en after rd_delay cycles (negative = never), then scrambles rd_data
    initial begin
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rd_en && !rst && rd_delay >= 0) begin
                if (rd_delay > 0) begin
                    repeat (rd_delay) @(posedge clk);
                    #1;
                end
                rd_data  = rd_val;
                rd_valid = 1'b1;
                @(posedge clk);
                #1;
                rd_valid = 1'b0;
                rd_data  = ~rd_val;
            end
        end
    end

    // Monitor: pops expectations on strobes and response rises, checks responses stay stable while held
    initial begin
        wr_t ew; b_t eb; rq_t eq; r_t er; w16_t e16;
        logic pb, pr;
        logic [1:0] pbresp;
        logic [33:0] prv;
        pb = 1'b0; pr = 1'b0; pbresp = '0; prv = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pb = 1'b0;
                pr = 1'b0;
            end else begin
                if (wr_en) begin
                    if (q_wr.size() == 0) chk("wr_en unexpected", {wr_idx, wr_data}, 0);
                    else begin
                        ew = q_wr.pop_front();
                        chk("wr strobe cyc/idx/data/strb", {cyc, wr_idx, wr_data, wr_strb}, {ew.c, ew.i, ew.d, ew.s});
                    end
                end
                if (bus.BVALID && !pb) begin
                    if (q_b.size() == 0) chk("bvalid unexpected", {30'd0, bus.BRESP}, 0);
                    else begin
                        eb = q_b.pop_front();
                        chk("b rise cyc/resp", {cyc, bus.BRESP}, {eb.c, eb.r});
                    end
                end else if (bus.BVALID && pb) chk("bresp held", bus.BRESP, pbresp);
                if (rd_en) begin
                    if (q_rd.size() == 0) chk("rd_en unexpected", rd_idx, 0);
                    else begin
                        eq = q_rd.pop_front();
                        chk("rd strobe cyc/idx", {cyc, rd_idx}, {eq.c, eq.i});
                    end
                end
                if (bus.RVALID && !pr) begin
                    if (q_r.size() == 0) chk("rvalid unexpected", {bus.RDATA, bus.RRESP}, 0);
                    else begin
                        er = q_r.pop_front();
                        chk("r rise cyc/data/resp", {cyc, bus.RDATA, bus.RRESP}, {er.c, er.d, er.r});
                    end
                end else if (bus.RVALID && pr) chk("rdata/rresp held", {bus.RDATA, bus.RRESP}, prv);
                if (wr_en16) begin
                    if (q_w16.size() == 0) chk("wr_en16 unexpected", {wr_idx16, wr_data16}, 0);
                    else begin
                        e16 = q_w16.pop_front();
                        chk("wr16 strobe cyc/idx/data/strb", {cyc, wr_idx16, wr_data16, wr_strb16}, {e16.c, e16.i, e16.d, e16.s});
                    end
                end
                if (rd_en16) chk("rd_en16 unexpected", rd_idx16, 0);
                pb = bus.BVALID;
                pbresp = bus.BRESP;
                pr = bus.RVALID;
                prv = {bus.RDATA, bus.RRESP};
            end
        end
    end

    task automatic exp_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input int c);
        if (a[7:2] < 6'd8) q_wr.push_back('{c, a[4:2], d, s});
        q_b.push_back('{c, (a[7:2] < 6'd8) ? 2'b00 : 2'b10});
    endtask

    task automatic aw(input logic [7:0] a, output int c);
        logic hs;
        hs = 1'b0;
        bus.AWADDR = a;
        bus.AWVALID = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = bus.AWREADY;
            @(posedge clk);
            #1;
        end
        if (!hs) chk("aw handshake timeout", 0, 1);
        bus.AWVALID = 1'b0;
        c = cyc;
    endtask

    task automatic w(input logic [31:0] d, input logic [3:0] s, output int c);
        logic hs;
        hs = 1'b0;
        bus.WDATA = d;
        bus.WSTRB = s;
        bus.WVALID = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = bus.WREADY;
            @(posedge clk);
            #1;
        end
        if (!hs) chk("w handshake timeout", 0, 1);
        bus.WVALID = 1'b0;
        c = cyc;
    endtask

    task automatic aw_w(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, output int c);
        logic hs;
        hs = 1'b0;
        bus.AWADDR = a;
        bus.WDATA = d;
        bus.WSTRB = s;
        bus.AWVALID = 1'b1;
        bus.WVALID = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = bus.AWREADY && bus.WREADY;
            @(posedge clk);
            #1;
        end
        if (!hs) chk("aw/w handshake timeout", 0, 1);
        bus.AWVALID = 1'b0;
        bus.WVALID = 1'b0;
        c = cyc;
    endtask

    // mode 0: AW and W together; 1: AW then W after gap; 2: W then AW after gap
    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input int mode, input int gap);
        int c1, c2;
        c1 = 0;
        c2 = 0;
        if (mode == 0) aw_w(a, d, s, c1);
        else if (mode == 1) begin
            aw(a, c1);
            repeat (gap) @(posedge clk);
            #1;
            w(d, s, c2);
        end else begin
            w(d, s, c2);
            repeat (gap) @(posedge clk);
            #1;
            aw(a, c1);
        end
        exp_wr(a, d, s, (c1 > c2) ? c1 : c2);
    endtask

    task automatic rd(input logic [7:0] a, input int dly, input logic [31:0] v, input bit exp_r);
        logic hs;
        int c;
        hs = 1'b0;
        rd_delay = dly;
        rd_val = v;
        bus.ARADDR = a;
        bus.ARVALID = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = bus.ARREADY;
            @(posedge clk);
            #1;
        end
        if (!hs) chk("ar handshake timeout", 0, 1);
        bus.ARVALID = 1'b0;
        c = cyc;
        if (a[7:2] < 6'd8) begin
            q_rd.push_back('{c, a[4:2]});
            if (exp_r) q_r.push_back('{(dly < 0) ? c + RDT : c + 1 + dly, (dly < 0) ? 32'd0 : v, (dly < 0) ? 2'b10 : 2'b00});
        end else if (exp_r) q_r.push_back('{c, 32'd0, 2'b10});
    endtask

    task automatic idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = bus.AWREADY && bus.WREADY && bus.ARREADY && !bus.BVALID && !bus.RVALID;
            if (!ok) begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) chk("return to idle timeout", 0, 1);
    endtask

    task automatic w16(input logic [7:0] a, input logic [15:0] d, input logic [1:0] s);
        logic hs;
        hs = 1'b0;
        bus16.AWADDR = a;
        bus16.WDATA = d;
        bus16.WSTRB = s;
        bus16.AWVALID = 1'b1;
        bus16.WVALID = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = bus16.AWREADY && bus16.WREADY;
            @(posedge clk);
            #1;
        end
        if (!hs) chk("w16 handshake timeout", 0, 1);
        bus16.AWVALID = 1'b0;
        bus16.WVALID = 1'b0;
        if (a[7:1] < 7'd8) q_w16.push_back('{cyc, a[3:1], d, s});
        chk("b16 valid/resp", {bus16.BVALID, bus16.BRESP}, {1'b1, (a[7:1] < 7'd8) ? 2'b00 : 2'b10});
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.AWVALID = 0; bus.AWADDR = 0; bus.WVALID = 0; bus.WDATA = 0; bus.WSTRB = 0;
        bus.BREADY = 1; bus.ARVALID = 0; bus.ARADDR = 0; bus.RREADY = 1;
        bus16.AWVALID = 0; bus16.AWADDR = 0; bus16.WVALID = 0; bus16.WDATA = 0; bus16.WSTRB = 0;
        bus16.BREADY = 1; bus16.ARVALID = 0; bus16.ARADDR = 0; bus16.RREADY = 1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset readies", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
        chk("reset valids/resps", {bus.BVALID, bus.RVALID, bus.BRESP, bus.RRESP}, 0);
        chk("reset rdata", bus.RDATA, 0);
        chk("reset strobes", {wr_en, rd_en}, 0);
        chk("reset16 readies", {bus16.AWREADY, bus16.WREADY, bus16.ARREADY, bus16.BVALID}, 4'b1110);
        rst = 1'b0;
        @(posedge clk);
        #1;

        wr(8'h08, 32'hDEADBEEF, 4'hF, 1, 3); idle();
        wr(8'h08, 32'hDEADBEEF, 4'hF, 2, 3); idle();
        wr(8'h08, 32'hDEADBEEF, 4'hF, 0, 0); idle();
        wr(8'h1F, 32'h0000_0000, 4'h0, 0, 0); idle();
        wr(8'h40, 32'h1111_2222, 4'hF, 0, 0); idle();

        rd(8'h04, 0, 32'hA5A5_0001, 1); idle();
        rd(8'h04, 3, 32'hA5A5_0003, 1); idle();
        rd(8'h04, RDT - 1, 32'hA5A5_000E, 1); idle();
        rd(8'h04, -1, 32'h0, 1); idle();
        rd(8'h7C, 0, 32'h0, 1); idle();

        bus.RREADY = 1'b0;
        fork
            rd(8'h10, 2, 32'hCAFE_F00D, 1);
            wr(8'h14, 32'h0BAD_F00D, 4'h5, 0, 0);
        join
        repeat (8) @(posedge clk);
        #1;
        bus.RREADY = 1'b1;
        idle();

        bus.BREADY = 1'b0;
        wr(8'h14, 32'h55AA_33CC, 4'hC, 0, 0);
        bus.AWADDR = 8'h18;
        bus.AWVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp aw/w ready low, bvalid high", {bus.AWREADY, bus.WREADY, bus.BVALID}, 3'b001);
            @(posedge clk);
            #1;
        end
        bus.BREADY = 1'b1;
        @(posedge clk);
        #1;
        chk("bp readies return after B", {bus.AWREADY, bus.WREADY, bus.BVALID}, 3'b110);
        wr(8'h18, 32'h0000_0077, 4'h1, 1, 1); idle();

        rd(8'h08, -1, 32'h0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset in R_WAIT outputs", {bus.ARREADY, bus.RVALID, bus.RRESP, rd_en}, 5'b10000);
        chk("reset in R_WAIT rdata", bus.RDATA, 0);
        repeat (RDT + 4) @(posedge clk);
        #1;
        chk("no late read response", {bus.ARREADY, bus.RVALID}, 2'b10);

        bus.BREADY = 1'b0;
        wr(8'h0C, 32'hFEED_FACE, 4'hF, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset with BVALID outputs", {bus.AWREADY, bus.WREADY, bus.BVALID, bus.BRESP, wr_en}, 6'b110000);
        bus.BREADY = 1'b1;
        wr(8'h10, 32'h1357_9BDF, 4'hA, 0, 0); idle();

        w16(8'h06, 16'hBEEF, 2'b01);
        w16(8'h0F, 16'h1234, 2'b10);
        w16(8'h10, 16'h5678, 2'b11);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard drained", q_wr.size() + q_b.size() + q_rd.size() + q_r.size() + q_w16.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
